ball_motion_ctrl: RTL and testbench

Sequences the ball position/velocity datapath for the ball-dynamics game.
- Serves the ball from a start position and velocity, and paces position updates with a programmable tick.
- Reflects velocity at the left, right and top walls, and flags a miss when the ball crosses the bottom edge.
- Sits between the game FSM (start/pause/abort) and the renderer, which consumes pos_x/pos_y.

---
 rtl/ball_pkg.sv | 42 ++++
 rtl/ball_axis_step.sv | 62 ++++++
 rtl/ball_motion_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and helpers for the ball motion controller.
//   ball_state_t : controller state encoding
//   DEF_POS_W / DEF_VEL_W : default position / velocity widths
//   sext_vel     : sign-extend the low w bits of a velocity to HELPER_W bits
//   negsat_vel   : sign-extend and pull the most negative code up by one so
//                  that a later negation of the velocity cannot overflow
package ball_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_RUN,
        ST_HOLD,
        ST_MISS
    } ball_state_t;

    localparam int DEF_POS_W = 4;
    localparam int DEF_VEL_W = 4;
    localparam int HELPER_W  = 16;

    function automatic logic signed [HELPER_W-1:0] sext_vel(
        input logic [HELPER_W-1:0] v,
        input int                  w
    );
        logic signed [HELPER_W-1:0] t;
        t = v << (HELPER_W - w);
        return t >>> (HELPER_W - w);
    endfunction

    function automatic logic signed [HELPER_W-1:0] negsat_vel(
        input logic [HELPER_W-1:0] v,
        input int                  w
    );
        logic signed [HELPER_W-1:0] s;
        logic signed [HELPER_W-1:0] lo;
        s  = sext_vel(v, w);
        lo = '1;
        lo = lo << (w - 1);
        return (s == lo) ? (s + 16'sd1) : s;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis position/velocity update (combinational).
//   pos, vel    : current position (unsigned) and velocity (two's complement)
//   max         : largest legal position on this axis
//   reflect_hi  : 1 = bounce off the high edge, 0 = report it only (bottom miss)
//   next_pos    : position after the update
//   next_vel    : velocity after the update (negated on a reflection)
//   hit_lo      : result went below 0 and was reflected
//   hit_hi      : result went above max (reflected only when reflect_hi = 1)
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int POS_W = DEF_POS_W,
    parameter int VEL_W = DEF_VEL_W
) (
    input  logic [POS_W-1:0] pos,
    input  logic [VEL_W-1:0] vel,
    input  logic [POS_W-1:0] max,
    input  logic             reflect_hi,
    output logic [POS_W-1:0] next_pos,
    output logic [VEL_W-1:0] next_vel,
    output logic             hit_lo,
    output logic             hit_hi
);

    // The sum itself fits in POS_W+2 signed bits; one extra bit keeps the
    // 2*max reflection free of overflow.
    localparam int W = POS_W + 3;

    logic signed [W-1:0] pos_s;
    logic signed [W-1:0] vel_s;
    logic signed [W-1:0] max_s;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] refl;

    always_comb begin
        pos_s    = signed'(W'(pos));
        max_s    = signed'(W'(max));
        vel_s    = W'(sext_vel(HELPER_W'(vel), VEL_W));
        sum      = pos_s + vel_s;
        refl     = '0;
        next_pos = pos;
        next_vel = vel;
        hit_lo   = 1'b0;
        hit_hi   = 1'b0;
        if (sum < 0) begin
            hit_lo   = 1'b1;
            refl     = -sum;
            next_vel = -vel;
            next_pos = (refl > max_s) ? max : POS_W'(refl);
        end else if (sum > max_s) begin
            hit_hi = 1'b1;
            if (reflect_hi) begin
                refl     = (max_s <<< 1) - sum;
                next_vel = -vel;
                next_pos = (refl < 0) ? '0 : POS_W'(refl);
            end
        end else begin
            next_pos = POS_W'(sum);
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball motion controller: serves the ball, paces position updates with a
// tick divider, reflects off the left/right/top walls and reports a miss
// when the ball crosses the bottom edge.
//   clk_50, reset_n         : clock, asynchronous active-low reset
//   start / pause / abort   : game FSM controls
//   serve_x/y, serve_vx/vy  : serve position and velocity
//   pos_x/y, vel_x/y        : current ball state for the renderer
//   step                    : one-cycle pulse when new pos/vel are visible
//   miss                    : one-cycle pulse on a bottom-edge crossing
//   busy                    : high in SERVE, RUN and HOLD
//   bounce_cnt              : reflecting updates since serve (only with
//                             BALL_BOUNCE_CNT_EN defined)
//
// state | meaning
// IDLE  | waiting for start
// SERVE | load serve position/velocity, clear tick counter (one cycle)
// RUN   | ball moving, update every TICK_DIV cycles
// HOLD  | paused, tick counter frozen
// MISS  | ball left through the bottom, position frozen until start
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int POS_W    = DEF_POS_W,
    parameter int VEL_W    = DEF_VEL_W,
    parameter int X_MAX    = 15,
    parameter int Y_MAX    = 15,
    parameter int TICK_DIV = 4
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [POS_W-1:0] serve_x,
    input  logic [POS_W-1:0] serve_y,
    input  logic [VEL_W-1:0] serve_vx,
    input  logic [VEL_W-1:0] serve_vy,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [VEL_W-1:0] vel_x,
    output logic [VEL_W-1:0] vel_y,
    output logic             step,
    output logic             miss,
    output logic             busy
`ifdef BALL_BOUNCE_CNT_EN
    ,
    output logic [7:0]       bounce_cnt
`endif
);

    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] X_LIM     = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_LIM     = POS_W'(Y_MAX);

    ball_state_t      state;
    ball_state_t      state_nxt;
    logic [CNT_W-1:0] tick;
    logic             upd_due;

    logic [POS_W-1:0] x_nxt;
    logic [POS_W-1:0] y_nxt;
    logic [VEL_W-1:0] vx_nxt;
    logic [VEL_W-1:0] vy_nxt;
    logic             x_lo;
    logic             x_hi;
    logic             y_lo;
    logic             y_hi;

    ball_axis_step #(.POS_W(POS_W), .VEL_W(VEL_W)) u_axis_x (
        .pos        (pos_x),
        .vel        (vel_x),
        .max        (X_LIM),
        .reflect_hi (1'b1),
        .next_pos   (x_nxt),
        .next_vel   (vx_nxt),
        .hit_lo     (x_lo),
        .hit_hi     (x_hi)
    );

    // The bottom edge is a miss, not a wall, so y never reflects high.
    ball_axis_step #(.POS_W(POS_W), .VEL_W(VEL_W)) u_axis_y (
        .pos        (pos_y),
        .vel        (vel_y),
        .max        (Y_LIM),
        .reflect_hi (1'b0),
        .next_pos   (y_nxt),
        .next_vel   (vy_nxt),
        .hit_lo     (y_lo),
        .hit_hi     (y_hi)
    );

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        upd_due   = (state == ST_RUN) && !pause && (tick == TICK_LAST);
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (start) state_nxt = ST_SERVE;
                ST_SERVE: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (pause) begin
                        state_nxt = ST_HOLD;
                    end else if (upd_due && y_hi) begin
                        state_nxt = ST_MISS;
                    end
                end
                ST_HOLD:  if (!pause) state_nxt = ST_RUN;
                ST_MISS:  if (start) state_nxt = ST_SERVE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
        busy = (state == ST_SERVE) || (state == ST_RUN) || (state == ST_HOLD);
    end

    // Abort leaves pos/vel and the counter untouched; a pause that coincides
    // with the update edge leaves the counter parked at TICK_LAST so the
    // update fires on the first RUN cycle after release.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            pos_x <= '0;
            pos_y <= '0;
            vel_x <= '0;
            vel_y <= '0;
            tick  <= '0;
            step  <= 1'b0;
            miss  <= 1'b0;
        end else begin
            step <= 1'b0;
            miss <= 1'b0;
            if (!abort) begin
                if (state == ST_SERVE) begin
                    pos_x <= (serve_x > X_LIM) ? X_LIM : serve_x;
                    pos_y <= (serve_y > Y_LIM) ? Y_LIM : serve_y;
                    vel_x <= VEL_W'(negsat_vel(HELPER_W'(serve_vx), VEL_W));
                    vel_y <= VEL_W'(negsat_vel(HELPER_W'(serve_vy), VEL_W));
                    tick  <= '0;
                end else if ((state == ST_RUN) && !pause) begin
                    if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (y_hi) begin
                            miss <= 1'b1;
                        end else begin
                            pos_x <= x_nxt;
                            pos_y <= y_nxt;
                            vel_x <= vx_nxt;
                            vel_y <= vy_nxt;
                            step  <= 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
            end
        end
    end

`ifdef BALL_BOUNCE_CNT_EN
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            bounce_cnt <= '0;
        end else if (!abort) begin
            if (state == ST_SERVE) begin
                bounce_cnt <= '0;
            end else if (upd_due && !y_hi && (x_lo || x_hi || y_lo) &&
                         (bounce_cnt != 8'hFF)) begin
                bounce_cnt <= bounce_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_hits;
    assign unused_hits = x_lo ^ x_hi ^ y_lo;
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
module tb_ball_motion_ctrl;

    localparam int POS_W    = 4;
    localparam int VEL_W    = 4;
    localparam int X_MAX    = 15;
    localparam int Y_MAX    = 15;
    localparam int TICK_DIV = 4;

    logic             clk_50   = 1'b0;
    logic             reset_n  = 1'b1;
    logic             start    = 1'b0;
    logic             pause    = 1'b0;
    logic             abort    = 1'b0;
    logic [POS_W-1:0] serve_x  = '0;
    logic [POS_W-1:0] serve_y  = '0;
    logic [VEL_W-1:0] serve_vx = '0;
    logic [VEL_W-1:0] serve_vy = '0;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic [VEL_W-1:0] vel_x;
    logic [VEL_W-1:0] vel_y;
    logic             step;
    logic             miss;
    logic             busy;
`ifdef BALL_BOUNCE_CNT_EN
    logic [7:0]       bounce_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // behavioural model of the ball
    int mx, my, mvx, mvy;

    ball_motion_ctrl #(
        .POS_W    (POS_W),
        .VEL_W    (VEL_W),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk_50   (clk_50),
        .reset_n  (reset_n),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .serve_x  (serve_x),
        .serve_y  (serve_y),
        .serve_vx (serve_vx),
        .serve_vy (serve_vy),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .vel_x    (vel_x),
        .vel_y    (vel_y),
        .step     (step),
        .miss     (miss),
        .busy     (busy)
`ifdef BALL_BOUNCE_CNT_EN
        ,
        .bounce_cnt (bounce_cnt)
`endif
    );

    always #10 clk_50 = ~clk_50;

    function automatic int s4(input logic [VEL_W-1:0] v);
        logic signed [VEL_W-1:0] t;
        t = v;
        return int'(t);
    endfunction

    // One axis of ball physics in plain integer arithmetic.
    function automatic void model_axis(input int p, input int v, input int mxv, input bit is_y,
                                       output int np, output int nv, output bit refl, output bit missed);
        int n;
        n = p + v;
        np = n; nv = v; refl = 1'b0; missed = 1'b0;
        if (n < 0) begin
            np = -n; nv = -v; refl = 1'b1;
            if (np > mxv) np = mxv;
        end else if (n > mxv) begin
            if (is_y) begin
                missed = 1'b1; np = p;
            end else begin
                np = 2 * mxv - n; nv = -v; refl = 1'b1;
                if (np < 0) np = 0;
            end
        end
    endfunction

    function automatic void model_serve(input int x, input int y, input int vx, input int vy);
        mx  = (x > X_MAX) ? X_MAX : x;
        my  = (y > Y_MAX) ? Y_MAX : y;
        mvx = (vx == -(1 << (VEL_W - 1))) ? vx + 1 : vx;
        mvy = (vy == -(1 << (VEL_W - 1))) ? vy + 1 : vy;
    endfunction

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic serve(input int x, input int y, input int vx, input int vy);
        serve_x  = POS_W'(x);
        serve_y  = POS_W'(y);
        serve_vx = VEL_W'(vx);
        serve_vy = VEL_W'(vy);
        start = 1'b1;
        clk_n(1);
        start = 1'b0;
        clk_n(1);
    endtask

    task automatic go_idle();
        abort = 1'b1;
        clk_n(1);
        abort = 1'b0;
    endtask

    task automatic wait_event(output int cyc, output bit got_step, output bit got_miss);
        cyc = 0; got_step = 1'b0; got_miss = 1'b0;
        while (!got_step && !got_miss && cyc < 4 * TICK_DIV + 4) begin
            clk_n(1);
            cyc++;
            got_step = step;
            got_miss = miss;
        end
    endtask

    task automatic test_reset();
        #5 reset_n = 1'b0;
        clk_n(2);
        total_cnt++;
        if ({pos_x, pos_y, vel_x, vel_y, step, miss, busy} !== '0)
            $display("FAIL reset_state: got %h expected 0", {pos_x, pos_y, vel_x, vel_y, step, miss, busy});
        else pass_cnt++;
        reset_n = 1'b1;
        clk_n(1);
        serve(3, 4, 1, 1);
        clk_n(2);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL busy_in_run: got %b expected 1", busy);
        else pass_cnt++;
        #3 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({pos_x, pos_y, vel_x, vel_y, step, miss, busy} !== '0)
            $display("FAIL async_reset: got %h expected 0", {pos_x, pos_y, vel_x, vel_y, step, miss, busy});
        else pass_cnt++;
        clk_n(1);
        reset_n = 1'b1;
        clk_n(2);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_first_step();
        int cyc; bit gs, gm;
        serve(0, 0, 1, 1);
        total_cnt++;
        if ({pos_x, pos_y, vel_x, vel_y, busy} !== {4'd0, 4'd0, 4'd1, 4'd1, 1'b1})
            $display("FAIL serve_load: got %0d,%0d v %0d,%0d busy %b", pos_x, pos_y, vel_x, vel_y, busy);
        else pass_cnt++;
        for (int k = 1; k <= 2; k++) begin
            wait_event(cyc, gs, gm);
            total_cnt++;
            if (!gs || cyc != TICK_DIV || pos_x !== POS_W'(k) || pos_y !== POS_W'(k))
                $display("FAIL step_timing %0d: step %b cyc %0d pos %0d,%0d expected cyc %0d pos %0d,%0d",
                         k, gs, cyc, pos_x, pos_y, TICK_DIV, k, k);
            else pass_cnt++;
        end
        clk_n(1);
        total_cnt++;
        if (step !== 1'b0) $display("FAIL step_one_cycle: step %b expected 0", step);
        else pass_cnt++;
    endtask

    task automatic test_walls();
        int tx[3]  = '{14, 1, 5};
        int ty[3]  = '{5, 5, 1};
        int tvx[3] = '{3, -3, 0};
        int tvy[3] = '{0, 0, -2};
        int ex[3]  = '{13, 2, 5};
        int ey[3]  = '{5, 5, 1};
        int evx[3] = '{-3, 3, 0};
        int evy[3] = '{0, 0, 2};
        int cyc; bit gs, gm;
        for (int i = 0; i < 3; i++) begin
            go_idle();
            serve(tx[i], ty[i], tvx[i], tvy[i]);
            wait_event(cyc, gs, gm);
            total_cnt++;
            if (!gs || {pos_x, pos_y, vel_x, vel_y} !==
                {POS_W'(ex[i]), POS_W'(ey[i]), VEL_W'(evx[i]), VEL_W'(evy[i])})
                $display("FAIL wall_%0d: step %b pos %0d,%0d vel %0d,%0d expected %0d,%0d vel %0d,%0d",
                         i, gs, pos_x, pos_y, s4(vel_x), s4(vel_y), ex[i], ey[i], evx[i], evy[i]);
            else pass_cnt++;
        end
        go_idle();
        serve(5, 14, 0, 2);
        wait_event(cyc, gs, gm);
        total_cnt++;
        if (!gm || gs || cyc != TICK_DIV || pos_y !== 4'd14 || vel_y !== 4'd2 || busy !== 1'b0)
            $display("FAIL bottom_miss: miss %b step %b cyc %0d pos_y %0d vel_y %0d busy %b expected 1 0 %0d 14 2 0",
                     gm, gs, cyc, pos_y, vel_y, busy, TICK_DIV);
        else pass_cnt++;
        clk_n(1);
        total_cnt++;
        if (miss !== 1'b0 || pos_y !== 4'd14) $display("FAIL miss_pulse: miss %b pos_y %0d expected 0 14", miss, pos_y);
        else pass_cnt++;
        serve(2, 2, 1, 0);
        total_cnt++;
        if (busy !== 1'b1 || pos_x !== 4'd2 || pos_y !== 4'd2)
            $display("FAIL serve_from_miss: busy %b pos %0d,%0d expected 1 2,2", busy, pos_x, pos_y);
        else pass_cnt++;
    endtask

    task automatic test_pause();
        int cyc; bit gs, gm, saw;
        go_idle();
        serve(3, 3, 1, 1);
        clk_n(TICK_DIV - 1);
        pause = 1'b1;
        saw = 1'b0;
        repeat (2 * TICK_DIV) begin
            clk_n(1);
            if (step || miss) saw = 1'b1;
        end
        total_cnt++;
        if (saw || pos_x !== 4'd3 || pos_y !== 4'd3 || busy !== 1'b1)
            $display("FAIL pause_hold: event %b pos %0d,%0d busy %b expected 0 3,3 1", saw, pos_x, pos_y, busy);
        else pass_cnt++;
        pause = 1'b0;
        wait_event(cyc, gs, gm);
        total_cnt++;
        if (!gs || cyc != 2 || pos_x !== 4'd4 || pos_y !== 4'd4)
            $display("FAIL pause_release: step %b cyc %0d pos %0d,%0d expected 1 2 4,4", gs, cyc, pos_x, pos_y);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        bit saw;
        go_idle();
        serve(6, 6, 1, 1);
        clk_n(2);
        abort = 1'b1; start = 1'b1;
        clk_n(1);
        abort = 1'b0; start = 1'b0;
        saw = 1'b0;
        repeat (2 * TICK_DIV) begin
            if (step || miss || busy) saw = 1'b1;
            clk_n(1);
        end
        total_cnt++;
        if (saw || pos_x !== 4'd6 || pos_y !== 4'd6)
            $display("FAIL abort_run: activity %b pos %0d,%0d expected 0 6,6", saw, pos_x, pos_y);
        else pass_cnt++;
        abort = 1'b1; start = 1'b1;
        clk_n(1);
        abort = 1'b0; start = 1'b0;
        clk_n(1);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_over_start: busy %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_sat_and_zero();
        int cyc; bit gs, gm;
        go_idle();
        serve(10, 10, -8, -8);
        total_cnt++;
        if (vel_x !== 4'b1001 || vel_y !== 4'b1001)
            $display("FAIL vel_saturate: vel %0d,%0d expected -7,-7", s4(vel_x), s4(vel_y));
        else pass_cnt++;
        wait_event(cyc, gs, gm);
        total_cnt++;
        if (!gs || pos_x !== 4'd3 || pos_y !== 4'd3)
            $display("FAIL sat_step: step %b pos %0d,%0d expected 3,3", gs, pos_x, pos_y);
        else pass_cnt++;
        go_idle();
        serve(7, 7, 0, 0);
        for (int k = 0; k < 2; k++) begin
            wait_event(cyc, gs, gm);
            total_cnt++;
            if (!gs || cyc != TICK_DIV || pos_x !== 4'd7 || pos_y !== 4'd7)
                $display("FAIL zero_vel %0d: step %b cyc %0d pos %0d,%0d expected 7,7", k, gs, cyc, pos_x, pos_y);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int cyc; bit gs, gm;
        int nx, ny, nvx, nvy;
        bit rx, ry, dm, mm;
        int x, y, vx, vy;
        for (int s = 0; s < 10; s++) begin
            go_idle();
            x  = int'($urandom_range(0, 15));
            y  = int'($urandom_range(0, 15));
            vx = s4(VEL_W'($urandom_range(0, 15)));
            vy = s4(VEL_W'($urandom_range(0, 15)));
            serve(x, y, vx, vy);
            model_serve(x, y, vx, vy);
            total_cnt++;
            if ({pos_x, pos_y, vel_x, vel_y} !== {POS_W'(mx), POS_W'(my), VEL_W'(mvx), VEL_W'(mvy)})
                $display("FAIL rnd_serve %0d: got %0d,%0d v %0d,%0d expected %0d,%0d v %0d,%0d",
                         s, pos_x, pos_y, s4(vel_x), s4(vel_y), mx, my, mvx, mvy);
            else pass_cnt++;
            for (int u = 0; u < 8; u++) begin
                model_axis(mx, mvx, X_MAX, 1'b0, nx, nvx, rx, dm);
                model_axis(my, mvy, Y_MAX, 1'b1, ny, nvy, ry, mm);
                wait_event(cyc, gs, gm);
                total_cnt++;
                if (mm) begin
                    if (!gm || gs || cyc != TICK_DIV || pos_x !== POS_W'(mx) || pos_y !== POS_W'(my) || busy !== 1'b0)
                        $display("FAIL rnd_miss %0d.%0d: miss %b step %b cyc %0d pos %0d,%0d expected pos %0d,%0d",
                                 s, u, gm, gs, cyc, pos_x, pos_y, mx, my);
                    else pass_cnt++;
                    break;
                end
                if (!gs || gm || cyc != TICK_DIV ||
                    {pos_x, pos_y, vel_x, vel_y} !== {POS_W'(nx), POS_W'(ny), VEL_W'(nvx), VEL_W'(nvy)})
                    $display("FAIL rnd_step %0d.%0d: step %b cyc %0d pos %0d,%0d v %0d,%0d expected %0d,%0d v %0d,%0d",
                             s, u, gs, cyc, pos_x, pos_y, s4(vel_x), s4(vel_y), nx, ny, nvx, nvy);
                else pass_cnt++;
                mx = nx; my = ny; mvx = nvx; mvy = nvy;
            end
        end
    endtask

`ifdef BALL_BOUNCE_CNT_EN
    task automatic test_bounce();
        int cyc; bit gs, gm;
        go_idle();
        serve(15, 0, 1, -1);
        total_cnt++;
        if (bounce_cnt !== 8'd0) $display("FAIL bounce_clear: got %0d expected 0", bounce_cnt);
        else pass_cnt++;
        wait_event(cyc, gs, gm);
        total_cnt++;
        if (!gs || pos_x !== 4'd14 || pos_y !== 4'd1 || bounce_cnt !== 8'd1)
            $display("FAIL corner_bounce: pos %0d,%0d cnt %0d expected 14,1 cnt 1", pos_x, pos_y, bounce_cnt);
        else pass_cnt++;
        wait_event(cyc, gs, gm);
        total_cnt++;
        if (!gs || bounce_cnt !== 8'd1)
            $display("FAIL bounce_hold: cnt %0d expected 1", bounce_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_first_step();
        test_walls();
        test_pause();
        test_abort();
        test_sat_and_zero();
        test_random();
`ifdef BALL_BOUNCE_CNT_EN
        test_bounce();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
